// File: rtl/conv_sram_arbiter.sv
// conv_sram_arbiter: shares one SRAM between a host requester and the XNOR convolution engine.
module conv_sram_arbiter #(
  parameter int BUSY_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [11:0]      host_addr,
  input  logic [15:0]      host_wdata,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [15:0]      host_rdata,
  output logic             eng_run,
  input  logic             eng_busy,
  input  logic [11:0]      eng_rd_addr,
  input  logic [11:0]      eng_wr_addr,
  input  logic [15:0]      eng_wr_data,
  input  logic             eng_wr_en,
  output logic [15:0]      eng_rd_data,
  output logic [11:0]      sram_rd_addr,
  output logic [11:0]      sram_wr_addr,
  output logic [15:0]      sram_wr_data,
  output logic             sram_we,
  input  logic [15:0]      sram_rd_data,
  output logic             owner,
  output logic             done,
  output logic [CNT_W-1:0] run_count,
  output logic             timeout_err
);
  localparam logic [2:0] S_HOST      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_ENG       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  logic [2:0] state, state_nx;
  logic [7:0] tcnt;
  logic       tmo;
  logic       in_host, in_wait, eng_end;
  assign in_host  = state == S_HOST;
  assign in_wait  = state == S_WAIT_BUSY;
  assign eng_end  = state == S_ENG && !eng_busy;
  // the BUSY_TIMEOUT-th idle wait cycle aborts the launch
  assign tmo      = in_wait && !eng_busy && tcnt == 8'(BUSY_TIMEOUT - 1);
  assign owner    = state == S_LAUNCH || in_wait || state == S_ENG;
  assign eng_run  = state == S_LAUNCH;
  assign done     = state == S_DONE;
  assign host_gnt = in_host && host_req && !start;
  assign host_rdata   = sram_rd_data;
  assign eng_rd_data  = sram_rd_data;
  assign sram_rd_addr = owner ? eng_rd_addr : host_addr;
  assign sram_wr_addr = owner ? eng_wr_addr : host_addr;
  assign sram_wr_data = owner ? eng_wr_data : host_wdata;
  assign sram_we      = owner ? eng_wr_en : host_gnt && host_we;
  always_comb begin
    state_nx = in_host                ? (start ? S_LAUNCH : S_HOST) :
               state == S_LAUNCH      ? S_WAIT_BUSY :
               in_wait                ? (eng_busy ? S_ENG : tmo ? S_HOST : S_WAIT_BUSY) :
               state == S_ENG         ? (eng_busy ? S_ENG : S_DONE) :
                                        S_HOST;
  end
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= S_HOST;
      tcnt        <= '0;
      host_rvalid <= 1'b0;
      run_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      host_rvalid <= host_gnt && !host_we;
      tcnt        <= (in_wait && !eng_busy && !tmo) ? tcnt + 8'd1 : 8'd0;
      if (in_host && start) timeout_err <= 1'b0;
      else if (tmo) timeout_err <= 1'b1;
      if (eng_end) run_count <= run_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_conv_sram_arbiter.sv
// tb_conv_sram_arbiter: directed checks of host access, engine launch, timeout, reset and wrap.
module tb_conv_sram_arbiter;
  logic        clk = 1'b0, reset_b = 1'b0, start = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_gnt, host_rvalid, eng_run, owner, done, timeout_err, sram_we;
  logic [15:0] host_rdata, eng_rd_data, sram_wr_data;
  logic [15:0] sram_rd_data = '0;
  logic        eng_busy = 1'b0, eng_wr_en = 1'b0;
  logic [11:0] eng_rd_addr = '0, eng_wr_addr = '0, sram_rd_addr, sram_wr_addr;
  logic [15:0] eng_wr_data = '0;
  logic [7:0]  run_count;
  logic [15:0] mem [4096];
  int n_tests = 0, n_fail = 0, n_run = 0, n_done = 0, run_base, done_base;

  conv_sram_arbiter #(.BUSY_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .eng_run(eng_run),
    .eng_busy(eng_busy), .eng_rd_addr(eng_rd_addr), .eng_wr_addr(eng_wr_addr),
    .eng_wr_data(eng_wr_data), .eng_wr_en(eng_wr_en), .eng_rd_data(eng_rd_data),
    .sram_rd_addr(sram_rd_addr), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_we(sram_we), .sram_rd_data(sram_rd_data), .owner(owner), .done(done),
    .run_count(run_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_we) mem[sram_wr_addr] <= sram_wr_data;
    sram_rd_data <= mem[sram_rd_addr];
  end

  always @(negedge clk) begin
    if (eng_run) n_run++;
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3;
    check("rst_owner", owner, 0);
    check("rst_run_count", run_count, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_done", done, 0);
    check("rst_eng_run", eng_run, 0);
    check("rst_rvalid", host_rvalid, 0);
    check("idle_gnt", host_gnt, 0);
    check("idle_we", sram_we, 0);
    #10 reset_b = 1'b1;

    cyc(); host_req = 1; host_we = 1; host_addr = 12'd5; host_wdata = 16'hBEEF; #1;
    check("wr_gnt", host_gnt, 1);
    check("wr_we", sram_we, 1);
    check("wr_data", sram_wr_data, 16'hBEEF);
    cyc(); host_we = 0; #1;
    check("rd_gnt", host_gnt, 1);
    check("rd_we", sram_we, 0);
    check("rd_addr", sram_rd_addr, 5);
    check("rd_rvalid_early", host_rvalid, 0);
    cyc(); host_req = 0; #1;
    check("rd_rvalid", host_rvalid, 1);
    check("rd_rdata", host_rdata, 16'hBEEF);
    check("rd_eng_rdata", eng_rd_data, 16'hBEEF);
    cyc(); #1;
    check("rd_rvalid_drop", host_rvalid, 0);

    for (int k = 0; k <= 24; k++) begin
      cyc();
      start = (k == 0); host_req = 1; host_we = 1; host_addr = 12'd9; host_wdata = 16'h1234;
      eng_busy = (k >= 2 && k <= 21); eng_wr_en = 1; eng_wr_addr = 12'd7;
      eng_rd_addr = 12'd3; eng_wr_data = 16'h5555;
      #1;
      check($sformatf("run_eng_run_%0d", k), eng_run, k == 1);
      check($sformatf("run_owner_%0d", k), owner, k >= 1 && k <= 22);
      check($sformatf("run_done_%0d", k), done, k == 23);
      check($sformatf("run_gnt_%0d", k), host_gnt, k == 24);
      check($sformatf("run_we_%0d", k), sram_we, (k >= 1 && k <= 22) || k == 24);
      check($sformatf("run_wa_%0d", k), sram_wr_addr, (k >= 1 && k <= 22) ? 7 : 9);
      check($sformatf("run_ra_%0d", k), sram_rd_addr, (k >= 1 && k <= 22) ? 3 : 9);
    end
    check("run_count_1", run_count, 1);
    cyc(); start = 0; eng_wr_en = 0; host_req = 1; host_we = 0; host_addr = 12'd9; #1;
    check("post_rd_gnt", host_gnt, 1);
    cyc(); host_req = 0; #1;
    check("post_rd_valid", host_rvalid, 1);
    check("post_rd_data", host_rdata, 16'h1234);

    for (int k = 0; k <= 17; k++) begin
      cyc(); start = (k == 0); eng_busy = 0; #1;
      check($sformatf("to_owner_%0d", k), owner, k >= 1 && k <= 16);
      check($sformatf("to_done_%0d", k), done, 0);
      check($sformatf("to_err_%0d", k), timeout_err, k == 17);
      check($sformatf("to_run_%0d", k), eng_run, k == 1);
    end
    check("to_run_count", run_count, 1);
    cyc(); start = 1; #1;
    check("to_err_hold", timeout_err, 1);
    cyc(); start = 0; #1;
    check("to_err_clear", timeout_err, 0);
    check("to_relaunch", eng_run, 1);
    cyc(); eng_busy = 1; #1;
    check("rst_pre_owner", owner, 1);
    cyc(); #1;
    check("rst_pre_count", run_count, 1);
    check("rst_pre_eng", owner, 1);
    reset_b = 0; #1;
    check("arst_owner", owner, 0);
    check("arst_eng_run", eng_run, 0);
    check("arst_done", done, 0);
    check("arst_count", run_count, 0);
    check("arst_err", timeout_err, 0);
    eng_busy = 0;
    cyc(); reset_b = 1;
    cyc(); host_req = 1; host_we = 1; host_addr = 12'd0; host_wdata = 16'h0; #1;
    check("arst_gnt", host_gnt, 1);
    check("arst_owner_after", owner, 0);
    cyc(); host_req = 0;

    run_base = n_run; done_base = n_done;
    for (int r = 0; r < 256; r++) begin
      cyc(); start = 1; eng_busy = 0;
      cyc(); start = 0;
      cyc(); eng_busy = 1;
      cyc(); start = 1;
      cyc(); start = 0; eng_busy = 0;
      cyc(); start = 1; #1;
      if (r == 254) check("wrap_255", run_count, 255);
    end
    cyc(); start = 0; #1;
    check("wrap_zero", run_count, 0);
    check("wrap_runs", n_run - run_base, 256);
    check("wrap_dones", n_done - done_base, 256);
    check("wrap_owner", owner, 0);
    cyc(); #1;
    check("wrap_no_queue", owner, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
